// File: rtl/mcycle_unit.sv
// Multi-cycle unsigned MUL/DIV engine for the Execute stage; raises Busy to stall the pipeline.
// Optional MCYCLE_EARLY_TERM_EN: MUL stops once the remaining multiplier bits are all zero.
module mcycle_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             opDiv;
    logic [WIDTH-1:0] acc;      // MUL: upper partial product; DIV: remainder
    logic [WIDTH-1:0] mq;       // MUL: multiplier / lower product; DIV: dividend / quotient
    logic [WIDTH-1:0] opB;      // MUL: multiplicand; DIV: divisor

    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divShift;
    logic [WIDTH-1:0] divDiff;
    logic             divKeep;
    logic [WIDTH-1:0] nextAcc;
    logic [WIDTH-1:0] nextMq;
    logic [WIDTH-1:0] finalLo;
    logic [WIDTH-1:0] finalHi;
    logic             lastStep;

    // One radix-2 step of shift-add multiply or restoring divide
    always_comb begin
        mulSum   = {1'b0, acc} + {1'b0, (mq[0] ? opB : '0)};
        divShift = {acc, mq[WIDTH-1]};
        divKeep  = (divShift >= {1'b0, opB});
        divDiff  = divShift[WIDTH-1:0] - opB;
        if (opDiv) begin
            nextAcc = divKeep ? divDiff : divShift[WIDTH-1:0];
            nextMq  = {mq[WIDTH-2:0], divKeep};
        end else begin
            nextAcc = mulSum[WIDTH:1];
            nextMq  = {mulSum[0], mq[WIDTH-1:1]};
        end
    end

`ifdef MCYCLE_EARLY_TERM_EN
    localparam logic [CW:0] LAST_STEP = (CW+1)'(WIDTH-1);

    logic [WIDTH-1:0]   remMask;
    logic [2*WIDTH-1:0] alignedProd;

    // Low bits of nextMq still holding unconsumed multiplier bits; product is aligned on exit
    always_comb begin
        remMask     = {WIDTH{1'b1}} >> ({1'b0, count} + (CW+1)'(1));
        lastStep    = (count == CW'(WIDTH-1)) || (!opDiv && ((nextMq & remMask) == '0));
        alignedProd = {nextAcc, nextMq} >> (LAST_STEP - {1'b0, count});
        finalLo     = alignedProd[WIDTH-1:0];
        finalHi     = alignedProd[2*WIDTH-1:WIDTH];
    end
`else
    always_comb begin
        lastStep = (count == CW'(WIDTH-1));
        finalLo  = nextMq;
        finalHi  = nextAcc;
    end
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            count   <= '0;
            opDiv   <= 1'b0;
            acc     <= '0;
            mq      <= '0;
            opB     <= '0;
            Result1 <= '0;
            Result2 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        opDiv <= MCycleOp;
                        acc   <= '0;
                        mq    <= MCycleOp ? Operand1 : Operand2;
                        opB   <= MCycleOp ? Operand2 : Operand1;
                        count <= '0;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    acc   <= nextAcc;
                    mq    <= nextMq;
                    count <= count + 1'b1;
                    if (lastStep) begin
                        Result1 <= finalLo;
                        Result2 <= finalHi;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stall request: asserted the same cycle Start arrives in IDLE, dropped in DONE
    assign Busy = !Reset && (((state == IDLE) && Start) || (state == COMPUTE));

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: directed corner cases plus random MUL/DIV against an arithmetic model.
// Honours MCYCLE_EARLY_TERM_EN for the expected Busy duration of MUL.
module tb_mcycle_unit;

`ifdef MCYCLE_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic        MCycleOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic        Busy;

    int          nAsserts = 0;
    int          nFails   = 0;
    logic [31:0] expR1    = '0;
    logic [31:0] expR2    = '0;

    always #5 CLK = ~CLK;

    mcycle_unit #(.WIDTH(32)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic; divide by zero gives all-ones quotient and the dividend as remainder
    task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r1, output logic [31:0] r2);
        logic [63:0] prod;
        prod = 64'(a) * 64'(b);
        if (!op) begin
            r1 = prod[31:0];
            r2 = prod[63:32];
        end else if (b == 32'd0) begin
            r1 = 32'hFFFF_FFFF;
            r2 = a;
        end else begin
            r1 = a / b;
            r2 = a % b;
        end
    endtask

    // Cycles Busy stays high: one IDLE cycle plus the COMPUTE steps
    function automatic int expBusy(input logic op, input logic [31:0] b);
        int msb;
        msb = 0;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        if (EARLY && !op) return msb + 2;
        return 33;
    endfunction

    // Called on a falling edge with the unit in IDLE; returns on the falling edge of DONE
    task automatic runOp(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                         input bit holdStart, input bit dropMid);
        int          n;
        logic [31:0] e1;
        logic [31:0] e2;
        model(op, a, b, e1, e2);
        Operand1 = a;
        Operand2 = b;
        MCycleOp = op;
        Start    = 1'b1;
        #1;
        n = 0;
        while (Busy === 1'b1 && n < 100) begin
            n++;
            @(negedge CLK);
            Operand1 = $urandom;
            Operand2 = $urandom;
            MCycleOp = 1'($urandom_range(0, 1));
            if (dropMid && n == 5) Start = 1'b0;
            #1;
            if (n == 3 && Busy === 1'b1)
                check({tag, "_midhold"}, {Result2, Result1}, {expR2, expR1});
        end
        check({tag, "_busycycles"}, 64'(n), 64'(expBusy(op, b)));
        check({tag, "_busydone"}, 64'(Busy), 64'(0));
        check({tag, "_result"}, {Result2, Result1}, {e2, e1});
        expR1 = e1;
        expR2 = e2;
        if (!holdStart) Start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        op;
        logic [31:0] a;
        logic [31:0] b;

        Reset    = 1'b1;
        Start    = 1'b0;
        MCycleOp = 1'b0;
        Operand1 = '0;
        Operand2 = '0;
        @(negedge CLK);
        #1;
        check("reset_busy", 64'(Busy), 64'(0));
        check("reset_results", {Result2, Result1}, 64'(0));
        Start = 1'b1;
        #1;
        check("reset_busy_forced", 64'(Busy), 64'(0));
        Start = 1'b0;
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);

        // Directed corners
        runOp("mul_7x6", 1'b0, 32'd7, 32'd6, 1'b0, 1'b0);
        @(negedge CLK);
        #1;
        check("idle_hold", {Result2, Result1}, {expR2, expR1});
        runOp("mul_7x0", 1'b0, 32'd7, 32'd0, 1'b0, 1'b0);
        @(negedge CLK);
        runOp("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge CLK);
        runOp("div_100_7", 1'b1, 32'd100, 32'd7, 1'b0, 1'b1);
        @(negedge CLK);
        runOp("div_5_0", 1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
        @(negedge CLK);
        runOp("div_max_0", 1'b1, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        @(negedge CLK);

        // Start held through DONE: one Busy-low cycle, then immediate restart
        runOp("b2b_first", 1'b0, 32'h1234_5678, 32'h0000_0F0F, 1'b1, 1'b0);
        @(negedge CLK);
        #1;
        check("b2b_rearm", 64'(Busy), 64'(1));
        runOp("b2b_second", 1'b1, 32'hFFFF_0000, 32'd3, 1'b0, 1'b0);
        @(negedge CLK);

        // Reset during COMPUTE step 10, released with Start already high
        Operand1 = 32'd123;
        Operand2 = 32'd456;
        MCycleOp = 1'b0;
        Start    = 1'b1;
        #1;
        repeat (11) @(negedge CLK);
        Reset = 1'b1;
        #1;
        check("midreset_busy", 64'(Busy), 64'(0));
        check("midreset_results", {Result2, Result1}, 64'(0));
        expR1 = '0;
        expR2 = '0;
        @(negedge CLK);
        Reset = 1'b0;
        runOp("post_reset", 1'b0, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge CLK);

        // Random operations
        for (int k = 0; k < 24; k++) begin
            op = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom >> $urandom_range(0, 31);
                2:       b = 32'd0;
                default: b = 32'($urandom_range(1, 15));
            endcase
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            runOp($sformatf("rand%0d", k), op, a, b, 1'b0, 1'b0);
            repeat (1 + $urandom_range(0, 2)) @(negedge CLK);
            #1;
            check($sformatf("rand%0d_idlehold", k), {Result2, Result1}, {expR2, expR1});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
